// File: rtl/vigna_bus_arbiter.sv
// Round-robin merge of the vigna instruction and data ports onto one shared memory port.
// One transaction in flight, registered request/response paths, optional timeout with sticky error.
module vigna_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TimeoutLast = TIMEOUT_CYCLES - 1;

  state_e      state_q, state_d;
  logic        last_was_d_q, last_was_d_d;
  logic [31:0] cnt_q, cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        bus_err_q, bus_err_d;

  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    cnt_d        = cnt_q;
    m_valid_d    = m_valid_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wstrb_d    = m_wstrb_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    bus_err_d    = bus_err_q;

    unique case (state_q)
      IDLE: begin
        // On contention the port that did not win last time goes first
        if (d_valid && (!i_valid || !last_was_d_q)) begin
          state_d      = BUSY_D;
          last_was_d_d = 1'b1;
          cnt_d        = 32'd0;
          m_valid_d    = 1'b1;
          m_addr_d     = d_addr;
          m_wdata_d    = d_wdata;
          m_wstrb_d    = d_wstrb;
        end else if (i_valid) begin
          state_d      = BUSY_I;
          last_was_d_d = 1'b0;
          cnt_d        = 32'd0;
          m_valid_d    = 1'b1;
          m_addr_d     = i_addr;
          m_wdata_d    = 32'd0;
          m_wstrb_d    = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        // A completion on the final count still beats the timeout
        if (m_ready || (TimeoutEn && (cnt_q == TimeoutLast))) begin
          state_d   = RESP;
          m_valid_d = 1'b0;
          if (!m_ready) begin
            bus_err_d = 1'b1;
          end
          if (state_q == BUSY_I) begin
            i_ready_d = 1'b1;
            i_rdata_d = m_ready ? m_rdata : ERR_DATA;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = m_ready ? m_rdata : ERR_DATA;
          end
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      cnt_q        <= 32'd0;
      m_valid_q    <= 1'b0;
      m_addr_q     <= 32'd0;
      m_wdata_q    <= 32'd0;
      m_wstrb_q    <= 4'd0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      cnt_q        <= cnt_d;
      m_valid_q    <= m_valid_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wstrb_q    <= m_wstrb_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed and randomized checks of vigna_bus_arbiter against a transaction-level
// model: arbitration winner, shared-port fields, hold time, response data and error flag.
module tb_vigna_bus_arbiter;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] ERRD    = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, i_ready, d_valid, d_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_rdata, d_wdata;
  logic [3:0]  d_wstrb, m_wstrb;
  logic        m_valid, m_ready, bus_err;
  logic [31:0] m_addr, m_rdata, m_wdata;

  int tests  = 0;
  int failed = 0;
  bit lastD  = 1'b0;
  bit errExp = 1'b0;

  vigna_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .ERR_DATA(ERRD)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_rdata(m_rdata),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, "_m_valid"}, m_valid, 1'b0);
    checkBit({tag, "_i_ready"}, i_ready, 1'b0);
    checkBit({tag, "_d_ready"}, d_ready, 1'b0);
    checkBit({tag, "_bus_err"}, bus_err, 1'b0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'd0);
    check({tag, "_m_wstrb"}, {28'd0, m_wstrb}, 32'd0);
    check({tag, "_i_rdata"}, i_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // Serves one transaction. The winner is predicted from the currently raised
  // valids and the model's last grant; memory answers after lat wait cycles.
  task automatic serveOne(input int lat, input logic [31:0] rd, input bit keep);
    bit          portD;
    bit          timedOut;
    int          cycles;
    int          expCycles;
    logic [31:0] eAddr, eWdata, eRdata;
    logic [3:0]  eStrb;
    portD     = d_valid && (!i_valid || !lastD);
    lastD     = portD;
    eAddr     = portD ? d_addr  : i_addr;
    eWdata    = portD ? d_wdata : 32'd0;
    eStrb     = portD ? d_wstrb : 4'd0;
    timedOut  = (lat >= int'(TIMEOUT));
    expCycles = timedOut ? int'(TIMEOUT) : lat + 1;
    eRdata    = timedOut ? ERRD : rd;
    errExp    = errExp | timedOut;

    tick();
    cycles = 0;
    while (m_valid === 1'b1 && cycles < 40) begin
      cycles++;
      check("m_addr", m_addr, eAddr);
      check("m_wdata", m_wdata, eWdata);
      check("m_wstrb", {28'd0, m_wstrb}, {28'd0, eStrb});
      checkBit("ready_during_busy", i_ready | d_ready, 1'b0);
      m_ready = (cycles == lat + 1);
      m_rdata = m_ready ? rd : $urandom;
      tick();
      m_ready = 1'b0;
    end
    check("m_valid_cycles", cycles, expCycles);
    checkBit("served_ready", portD ? d_ready : i_ready, 1'b1);
    checkBit("other_ready", portD ? i_ready : d_ready, 1'b0);
    check("served_rdata", portD ? d_rdata : i_rdata, eRdata);
    checkBit("bus_err", bus_err, errExp);

    // The served master still drives valid during the response cycle,
    // and a stray m_ready here must have no effect
    m_ready = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    tick();
    m_ready = 1'b0;
    checkBit("post_i_ready", i_ready, 1'b0);
    checkBit("post_d_ready", d_ready, 1'b0);
    checkBit("post_m_valid", m_valid, 1'b0);
    if (!keep) begin
      if (portD) d_valid = 1'b0;
      else       i_valid = 1'b0;
    end
  endtask

  initial begin
    resetn  = 1'b0;
    i_valid = 1'b0; i_addr  = 32'd0;
    d_valid = 1'b0; d_addr  = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0;
    m_ready = 1'b0; m_rdata = 32'd0;
    tick();
    tick();
    checkAllZero("reset");
    resetn = 1'b1;
    tick();

    // Single fetch with two wait cycles
    i_valid = 1'b1; i_addr = 32'h8;
    serveOne(2, 32'h00A00093, 1'b0);

    // Simultaneous after reset: D then I
    i_valid = 1'b1; i_addr = 32'h20;
    d_valid = 1'b1; d_addr = 32'h10; d_wdata = 32'h0; d_wstrb = 4'd0;
    serveOne(1, 32'h11111111, 1'b0);
    serveOne(0, 32'h22222222, 1'b0);
    // A lone data access, then a pair: I now wins first
    d_valid = 1'b1; d_addr = 32'h30;
    serveOne(0, 32'h33333333, 1'b0);
    i_valid = 1'b1; i_addr = 32'h40;
    d_valid = 1'b1; d_addr = 32'h44;
    serveOne(1, 32'h44444444, 1'b0);
    serveOne(2, 32'h55555555, 1'b0);

    // Store held stable across wait cycles
    d_valid = 1'b1; d_addr = 32'h14; d_wdata = 32'h1234ABCD; d_wstrb = 4'b0011;
    serveOne(3, 32'h0, 1'b0);

    // Memory never answers
    i_valid = 1'b1; i_addr = 32'h100;
    serveOne(1000, 32'h0, 1'b0);
    // Completion on the final count is normal; error flag stays sticky
    d_valid = 1'b1; d_addr = 32'h104; d_wstrb = 4'd0;
    serveOne(int'(TIMEOUT) - 1, 32'hCAFEF00D, 1'b0);

    // Valid held through the response and beyond is served again, once
    i_valid = 1'b1; i_addr = 32'h200;
    serveOne(0, 32'h0BADF00D, 1'b1);
    serveOne(1, 32'h600DF00D, 1'b0);

    // Reset in the middle of a data transaction, memory answering throughout
    d_valid = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5A5A5; d_wstrb = 4'hF;
    tick();
    checkBit("busy_d_m_valid", m_valid, 1'b1);
    resetn  = 1'b0;
    m_ready = 1'b1; m_rdata = 32'h55555555;
    tick();
    checkAllZero("midreset");
    tick();
    d_valid = 1'b0;
    resetn  = 1'b1;
    lastD   = 1'b0;
    errExp  = 1'b0;
    tick();
    checkBit("after_rst_d_ready", d_ready, 1'b0);
    checkBit("after_rst_m_valid", m_valid, 1'b0);
    m_ready = 1'b0;
    tick();
    checkAllZero("after_rst");
    i_valid = 1'b1; i_addr = 32'h50;
    d_valid = 1'b1; d_addr = 32'h54; d_wstrb = 4'd0;
    serveOne(0, 32'h12121212, 1'b0);
    serveOne(0, 32'h34343434, 1'b0);

    // Randomized traffic: fetch only, data only, or both at once
    for (int n = 0; n < 40; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode != 1) begin
        i_valid = 1'b1;
        i_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (mode != 0) begin
        d_valid = 1'b1;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(0, 15));
      end
      serveOne($urandom_range(0, 5), $urandom, 1'b0);
      if (mode == 2) begin
        serveOne($urandom_range(0, 5), $urandom, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
